// File: rtl/polara_noc_rx_checker_if.sv
// Flit channel from the chip into the chipset-side checker.
// Latency: none, wires only.
// Backpressure: valid/ready; a flit moves on any edge where in_val and in_rdy are both high.
interface polara_noc_rx_checker_if #(
  parameter int DATA_WIDTH = 64
) ();
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_val;
  logic                  in_rdy;

  // Chip side: drives flits, observes ready.
  modport master (
    output in_data,
    output in_val,
    input  in_rdy
  );

  // Checker side: consumes flits, drives ready.
  modport slave (
    input  in_data,
    input  in_val,
    output in_rdy
  );
endinterface

// File: rtl/polara_noc_rx_checker.sv
// NoC sink: parses OpenPiton headers, walks payloads by length, checks A/B pattern and header type/length.
// Latency: every status output is a flop updated on the edge that accepts the flit.
// Backpressure: in_rdy is enable registered; a stall holds packet position and checking resumes in place.
module polara_noc_rx_checker #(
  parameter int                    DATA_WIDTH  = 64,
  parameter int                    CNT_WIDTH   = 32,
  parameter logic [7:0]            MAX_PAYLOAD = 8'd6,
  parameter logic [DATA_WIDTH-1:0] PATTERN_A   = {DATA_WIDTH{1'b1}},
  parameter logic [DATA_WIDTH-1:0] PATTERN_B   = {DATA_WIDTH{1'b0}}
) (
  input  logic                   chipset_clk,
  input  logic                   chipset_rst_n,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [7:0]             exp_msg_type,
  input  logic                   check_type_en,
  polara_noc_rx_checker_if.slave noc,
  output logic [CNT_WIDTH-1:0]   pkt_count,
  output logic [CNT_WIDTH-1:0]   flit_count,
  output logic [CNT_WIDTH-1:0]   err_count,
  output logic                   err_sticky,
  output logic [DATA_WIDTH-1:0]  first_err_data,
  output logic [1:0]             first_err_code,
  output logic                   busy
);

  // Header field positions inside a flit.
  localparam int LEN_LSB  = 22;
  localparam int TYPE_LSB = 14;

  // Error cause encoding for first_err_code; length outranks type on a header carrying both.
  localparam logic [1:0] ERR_PATTERN = 2'd1;
  localparam logic [1:0] ERR_TYPE    = 2'd2;
  localparam logic [1:0] ERR_LENGTH  = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_HEADER  = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [7:0]     len_q;
  logic [7:0]     len_d;
  logic [7:0]     idx_q;
  logic [7:0]     idx_d;

  logic           rdy_q;
  logic           accept;
  logic [7:0]     hdr_len;
  logic [7:0]     hdr_type;
  logic           pkt_done;
  logic           type_err;
  logic           len_err;
  logic           pat_err;
  logic           any_err;
  logic [1:0]     err_inc;
  logic [1:0]     err_code;
  logic [CNT_WIDTH:0] err_sum;

  assign noc.in_rdy = rdy_q;
  assign accept     = noc.in_val && rdy_q;
  assign hdr_len    = noc.in_data[LEN_LSB +: 8];
  assign hdr_type   = noc.in_data[TYPE_LSB +: 8];

  // Ready simply follows enable one edge later, independent of clear.
  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= enable;
    end
  end

  // Packet walker: decides the next state, packet position and which checks fire for this flit.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    pkt_done = 1'b0;
    type_err = 1'b0;
    len_err  = 1'b0;
    pat_err  = 1'b0;
    if (accept) begin
      case (state_q)
        ST_HEADER: begin
          len_d    = hdr_len;
          idx_d    = 8'd0;
          type_err = check_type_en && (hdr_type != exp_msg_type);
          // An oversized packet is flagged but still consumed whole so framing stays aligned.
          len_err  = (hdr_len > MAX_PAYLOAD);
          if (hdr_len == 8'd0) begin
            pkt_done = 1'b1;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          pat_err = (noc.in_data != (idx_q[0] ? PATTERN_B : PATTERN_A));
          if (idx_q == (len_q - 8'd1)) begin
            pkt_done = 1'b1;
            state_d  = ST_HEADER;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
        default: begin
          state_d = ST_HEADER;
        end
      endcase
    end
    // Clear discards whatever packet was in flight, including a flit accepted this cycle.
    if (clear) begin
      state_d = ST_HEADER;
      len_d   = 8'd0;
      idx_d   = 8'd0;
    end
  end

  // Error summary for this cycle: how many errors to add and which cause to record if first.
  always_comb begin
    err_inc  = {1'b0, type_err} + {1'b0, len_err} + {1'b0, pat_err};
    any_err  = type_err || len_err || pat_err;
    err_code = ERR_PATTERN;
    if (len_err) begin
      err_code = ERR_LENGTH;
    end else if (type_err) begin
      err_code = ERR_TYPE;
    end
    err_sum = {1'b0, err_count} + {{(CNT_WIDTH-1){1'b0}}, err_inc};
  end

  // Packet walker state register.
  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) begin
      state_q <= ST_HEADER;
      len_q   <= 8'd0;
      idx_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
    end
  end

  // Mirror of the walker state for readout: high while between header and last payload flit.
  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_d == ST_PAYLOAD);
    end
  end

  // Saturating packet and flit counters.
  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) begin
      pkt_count  <= '0;
      flit_count <= '0;
    end else if (clear) begin
      pkt_count  <= '0;
      flit_count <= '0;
    end else begin
      if (accept && (flit_count != CNT_MAX)) begin
        flit_count <= flit_count + CNT_ONE;
      end
      if (pkt_done && (pkt_count != CNT_MAX)) begin
        pkt_count <= pkt_count + CNT_ONE;
      end
    end
  end

  // Saturating error counter; a header can contribute two errors in one cycle.
  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) begin
      err_count <= '0;
    end else if (clear) begin
      err_count <= '0;
    end else if (any_err) begin
      err_count <= err_sum[CNT_WIDTH] ? CNT_MAX : err_sum[CNT_WIDTH-1:0];
    end
  end

  // First-error capture: loads only while the sticky flag is still clear.
  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) begin
      err_sticky     <= 1'b0;
      first_err_data <= '0;
      first_err_code <= 2'd0;
    end else if (clear) begin
      err_sticky     <= 1'b0;
      first_err_data <= '0;
      first_err_code <= 2'd0;
    end else if (any_err && !err_sticky) begin
      err_sticky     <= 1'b1;
      first_err_data <= noc.in_data;
      first_err_code <= err_code;
    end
  end

endmodule

// File: tb/tb_polara_noc_rx_checker.sv
// Bench for polara_noc_rx_checker: packet-level reference model checked every cycle plus directed scenarios.
// Latency: model state is compared on the falling edge after each accepting rising edge.
// Backpressure: flits are held on the bus until the model reports them accepted, with a bounded wait.
module tb_polara_noc_rx_checker;

  localparam int          DW               = 64;
  localparam logic [7:0]  MSG_TYPE_INV_FWD = 8'd18;
  localparam logic [63:0] PAT_A            = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] PAT_B            = 64'h0;
  localparam longint      CMAX             = 64'h0000_0000_FFFF_FFFF;

  logic       clk           = 1'b0;
  logic       rst_n         = 1'b0;
  logic       enable        = 1'b0;
  logic       clear         = 1'b0;
  logic       check_type_en = 1'b0;
  logic [7:0] exp_msg_type  = 8'd0;

  always #5 clk = ~clk;

  polara_noc_rx_checker_if #(.DATA_WIDTH(DW)) dif ();
  polara_noc_rx_checker_if #(.DATA_WIDTH(DW)) sif ();

  logic [31:0]   pkt_count, flit_count, err_count;
  logic          err_sticky, busy;
  logic [DW-1:0] first_err_data;
  logic [1:0]    first_err_code;

  logic [3:0]    s_pkt, s_flit, s_err;
  logic          s_sticky, s_busy;
  logic [DW-1:0] s_fdata;
  logic [1:0]    s_fcode;

  polara_noc_rx_checker u_dut (
    .chipset_clk    (clk),
    .chipset_rst_n  (rst_n),
    .enable         (enable),
    .clear          (clear),
    .exp_msg_type   (exp_msg_type),
    .check_type_en  (check_type_en),
    .noc            (dif),
    .pkt_count      (pkt_count),
    .flit_count     (flit_count),
    .err_count      (err_count),
    .err_sticky     (err_sticky),
    .first_err_data (first_err_data),
    .first_err_code (first_err_code),
    .busy           (busy)
  );

  polara_noc_rx_checker #(.CNT_WIDTH(4)) u_sat (
    .chipset_clk    (clk),
    .chipset_rst_n  (rst_n),
    .enable         (enable),
    .clear          (clear),
    .exp_msg_type   (exp_msg_type),
    .check_type_en  (check_type_en),
    .noc            (sif),
    .pkt_count      (s_pkt),
    .flit_count     (s_flit),
    .err_count      (s_err),
    .err_sticky     (s_sticky),
    .first_err_data (s_fdata),
    .first_err_code (s_fcode),
    .busy           (s_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] hdr(input logic [7:0] len, input logic [7:0] mtype);
    hdr = (64'(len) << 22) | (64'(mtype) << 14);
  endfunction

  // Reference model: tracks where we are in the current packet and what the statistics must read.
  bit          m_rdy = 0, m_acc = 0, m_sticky = 0, m_inpkt = 0;
  longint      m_pkt = 0, m_flit = 0, m_err = 0;
  logic [63:0] m_fdata = '0;
  logic [1:0]  m_fcode = '0;
  int          m_plen = 0, m_pos = 0, m_nerr = 0;
  logic [1:0]  m_code;
  logic [63:0] m_expect;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rdy = 0; m_acc = 0; m_sticky = 0; m_inpkt = 0;
      m_pkt = 0; m_flit = 0; m_err = 0; m_fdata = '0; m_fcode = '0;
      m_plen = 0; m_pos = 0;
    end else begin
      m_acc = dif.in_val && m_rdy;
      if (clear) begin
        m_sticky = 0; m_inpkt = 0; m_pkt = 0; m_flit = 0; m_err = 0;
        m_fdata = '0; m_fcode = '0; m_plen = 0; m_pos = 0;
      end else if (m_acc) begin
        m_flit = (m_flit >= CMAX) ? CMAX : m_flit + 1;
        m_nerr = 0;
        m_code = 2'd0;
        if (!m_inpkt) begin
          m_plen = int'(dif.in_data[29:22]);
          m_pos  = 0;
          if (check_type_en && (dif.in_data[21:14] != exp_msg_type)) begin
            m_nerr++; m_code = 2'd2;
          end
          if (m_plen > 6) begin
            m_nerr++; m_code = 2'd3;
          end
          if (m_plen == 0) m_pkt = (m_pkt >= CMAX) ? CMAX : m_pkt + 1;
          else m_inpkt = 1;
        end else begin
          m_expect = (m_pos % 2 == 0) ? PAT_A : PAT_B;
          if (dif.in_data !== m_expect) begin
            m_nerr++; m_code = 2'd1;
          end
          m_pos++;
          if (m_pos == m_plen) begin
            m_pkt = (m_pkt >= CMAX) ? CMAX : m_pkt + 1;
            m_inpkt = 0;
          end
        end
        if (m_nerr > 0) begin
          m_err = (m_err + m_nerr > CMAX) ? CMAX : m_err + m_nerr;
          if (!m_sticky) begin
            m_sticky = 1; m_fdata = dif.in_data; m_fcode = m_code;
          end
        end
      end
      m_rdy = enable;
    end
  end

  // Compare every output of the main instance against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_in_rdy",         64'(dif.in_rdy),       64'(m_rdy));
      chk("cyc_pkt_count",      64'(pkt_count),        64'(m_pkt));
      chk("cyc_flit_count",     64'(flit_count),       64'(m_flit));
      chk("cyc_err_count",      64'(err_count),        64'(m_err));
      chk("cyc_err_sticky",     64'(err_sticky),       64'(m_sticky));
      chk("cyc_first_err_data", first_err_data,        m_fdata);
      chk("cyc_first_err_code", 64'(first_err_code),   64'(m_fcode));
      chk("cyc_busy",           64'(busy),             64'(m_inpkt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d);
    int n;
    dif.in_val  = 1'b1;
    dif.in_data = d;
    n = 0;
    do begin
      step();
      n++;
    end while (!m_acc && n < 40);
    if (!m_acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: flit %0h not accepted after %0d cycles, required acceptance", d, n);
    end
    dif.in_val = 1'b0;
  endtask

  task automatic do_reset();
    dif.in_val = 1'b0;
    sif.in_val = 1'b0;
    clear      = 1'b0;
    rst_n      = 1'b0;
    step();
    step();
    #2 rst_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    dif.in_val  = 1'b0;
    dif.in_data = '0;
    sif.in_val  = 1'b0;
    sif.in_data = '0;
    exp_msg_type  = MSG_TYPE_INV_FWD;
    check_type_en = 1'b1;
    step();
    chk_on = 1'b1;

    // Reset state with enable still low.
    do_reset();
    chk("rst_in_rdy", 64'(dif.in_rdy), 64'd0);
    chk("rst_pkt",    64'(pkt_count), 64'd0);
    chk("rst_err",    64'(err_count), 64'd0);
    chk("rst_code",   64'(first_err_code), 64'd0);
    chk("rst_busy",   64'(busy), 64'd0);

    // Good traffic: 10 packets of len 6.
    enable = 1'b1;
    step();
    chk("en_in_rdy", 64'(dif.in_rdy), 64'd1);
    for (int p = 0; p < 10; p++) begin
      send(hdr(8'd6, MSG_TYPE_INV_FWD));
      for (int i = 0; i < 6; i++) send((i % 2 == 0) ? PAT_A : PAT_B);
    end
    step();
    chk("good_pkt",    64'(pkt_count),  64'd10);
    chk("good_flit",   64'(flit_count), 64'd70);
    chk("good_err",    64'(err_count),  64'd0);
    chk("good_sticky", 64'(err_sticky), 64'd0);

    // Pattern error: 4th payload flit of packet 3 corrupted.
    do_reset();
    for (int p = 0; p < 10; p++) begin
      send(hdr(8'd6, MSG_TYPE_INV_FWD));
      for (int i = 0; i < 6; i++)
        send((p == 2 && i == 3) ? 64'h1 : ((i % 2 == 0) ? PAT_A : PAT_B));
    end
    step();
    chk("pat_err",   64'(err_count), 64'd1);
    chk("pat_code",  64'(first_err_code), 64'd1);
    chk("pat_data",  first_err_data, 64'h1);
    chk("pat_pkt",   64'(pkt_count), 64'd10);

    // Type and length errors on one header, oversized packet still consumed.
    do_reset();
    send(hdr(8'd9, 8'h00));
    for (int i = 0; i < 9; i++) send((i % 2 == 0) ? PAT_A : PAT_B);
    step();
    chk("tl_err",  64'(err_count), 64'd2);
    chk("tl_code", 64'(first_err_code), 64'd3);
    chk("tl_data", first_err_data, 64'h0000_0000_0240_0000);
    chk("tl_pkt",  64'(pkt_count), 64'd1);
    chk("tl_flit", 64'(flit_count), 64'd10);
    chk("tl_busy", 64'(busy), 64'd0);

    // Zero-length headers (type check off), then a stalled len 6 packet.
    do_reset();
    check_type_en = 1'b0;
    for (int i = 0; i < 3; i++) send(hdr(8'd0, 8'h00));
    check_type_en = 1'b1;
    send(hdr(8'd6, MSG_TYPE_INV_FWD));
    send(PAT_A);
    enable = 1'b0;
    send(PAT_B);
    dif.in_val  = 1'b1;
    dif.in_data = PAT_A;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_rdy",  64'(dif.in_rdy), 64'd0);
      chk("stall_flit", 64'(flit_count), 64'd6);
    end
    enable = 1'b1;
    for (int i = 2; i < 6; i++) send((i % 2 == 0) ? PAT_A : PAT_B);
    step();
    chk("zs_pkt",  64'(pkt_count), 64'd4);
    chk("zs_flit", 64'(flit_count), 64'd10);
    chk("zs_err",  64'(err_count), 64'd0);

    // Clear on the 3rd payload flit, then header parsing resumes.
    do_reset();
    send(hdr(8'd6, MSG_TYPE_INV_FWD));
    send(PAT_A);
    send(PAT_B);
    clear = 1'b1;
    send(PAT_A);
    clear = 1'b0;
    chk("clr_pkt",  64'(pkt_count), 64'd0);
    chk("clr_flit", 64'(flit_count), 64'd0);
    chk("clr_busy", 64'(busy), 64'd0);
    send(hdr(8'd0, MSG_TYPE_INV_FWD));
    chk("clr_next_pkt",  64'(pkt_count), 64'd1);
    chk("clr_next_flit", 64'(flit_count), 64'd1);
    chk("clr_next_err",  64'(err_count), 64'd0);

    // Asynchronous reset mid-packet, observed before any clock edge.
    send(hdr(8'd6, MSG_TYPE_INV_FWD));
    send(PAT_A);
    send(PAT_B);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_rdy", 64'(dif.in_rdy), 64'd0);
    chk("arst_pkt",    64'(pkt_count), 64'd0);
    chk("arst_flit",   64'(flit_count), 64'd0);
    chk("arst_busy",   64'(busy), 64'd0);
    do_reset();

    // Saturation on the 4-bit instance: 20 mismatching zero-length headers.
    step();
    sif.in_data = hdr(8'd0, 8'h00);
    sif.in_val  = 1'b1;
    repeat (20) step();
    sif.in_val  = 1'b0;
    step();
    chk("sat_pkt",    64'(s_pkt), 64'hF);
    chk("sat_flit",   64'(s_flit), 64'hF);
    chk("sat_err",    64'(s_err), 64'hF);
    chk("sat_sticky", 64'(s_sticky), 64'd1);
    chk("sat_code",   64'(s_fcode), 64'd2);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
